// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the input-conditioning blocks (debouncers, synchronisers).
package debounce_pkg;

   localparam int DEF_DELAY       = 1000000;
   localparam int DEF_SYNC_STAGES = 2;

   // Per-channel registered outputs, bundled so the top can fan them out by field.
   typedef struct packed {
      logic clean;
      logic rise;
      logic fall;
      logic busy;
   } chan_out_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // A DELAY of 0 still needs a one-bit counter to compare against.
   function automatic int cnt_width(input int delay);
      int w;
      w = clog2(delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Raw-input / debounced-output bundle between board pins and the debouncer.
interface debounce_multi_if #(parameter int N = 8);

   logic [N-1:0] noisy;
   logic [N-1:0] clean;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] busy;

   modport master (output noisy, input clean, input rise, input fall, input busy);
   modport slave  (input noisy, output clean, output rise, output fall, output busy);

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, candidate level, stability counter, clean level and edge pulses.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int DELAY       = DEF_DELAY,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter bit INIT        = 1'b0
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      noisy,
   output chan_out_t st
);

   localparam int            CW   = cnt_width(DELAY);
   localparam logic [CW-1:0] CMAX = CW'(DELAY);

   logic [SYNC_STAGES-1:0] sync;
   logic                   cand;
   logic                   clean_q;
   logic                   rise_q;
   logic                   fall_q;
   logic [CW-1:0]          cnt;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         sync    <= {SYNC_STAGES{INIT}};
         cand    <= INIT;
         clean_q <= INIT;
         cnt     <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], noisy};
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         // Any change of the synchronised level restarts qualification.
         if (s != cand) begin
            cand <= s;
            cnt  <= '0;
         end else if (cnt == CMAX) begin
            if (clean_q != cand) begin
               clean_q <= cand;
               rise_q  <= cand;
               fall_q  <= ~cand;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign st = '{clean: clean_q, rise: rise_q, fall: fall_q, busy: cand ^ clean_q};

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels sharing one DELAY / SYNC_STAGES setting.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int           N           = 8,
   parameter int           DELAY       = DEF_DELAY,
   parameter int           SYNC_STAGES = DEF_SYNC_STAGES,
   parameter logic [N-1:0] INIT        = '0
) (
   input  logic             clock,
   input  logic             reset,
   debounce_multi_if.slave  bus
);

   chan_out_t [N-1:0] st;

   generate
      for (genvar i = 0; i < N; i++) begin : g_chan
         debounce_chan #(
            .DELAY       (DELAY),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT        (INIT[i])
         ) u_chan (
            .clock (clock),
            .reset (reset),
            .noisy (bus.noisy[i]),
            .st    (st[i])
         );
      end
   endgenerate

   always_comb begin
      bus.clean = '0;
      bus.rise  = '0;
      bus.fall  = '0;
      bus.busy  = '0;
      for (int i = 0; i < N; i++) begin
         bus.clean[i] = st[i].clean;
         bus.rise[i]  = st[i].rise;
         bus.fall[i]  = st[i].fall;
         bus.busy[i]  = st[i].busy;
      end
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N=4, DELAY=4, SYNC_STAGES=2): expected {clean,rise,fall,busy} per edge.
module tb_debounce_multi;

   logic clock;
   logic reset;
   int   total;
   int   bad;
   logic [15:0] sbq[$];

   debounce_multi_if #(.N(4)) bus ();

   debounce_multi #(.N(4), .DELAY(4), .SYNC_STAGES(2), .INIT(4'b0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] e(input logic [3:0] c, input logic [3:0] r,
                                     input logic [3:0] f, input logic [3:0] b);
      return {c, r, f, b};
   endfunction

   task automatic push_n(input int n, input logic [15:0] v);
      repeat (n) sbq.push_back(v);
   endtask

   task automatic test_reset();
      logic [15:0] got, want;
      reset = 1'b1;
      bus.noisy = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         @(posedge clock); #1;
         got = {bus.clean, bus.rise, bus.fall, bus.busy};
         total++;
         if (got !== 16'h0000) begin
            bad++;
            $display("FAIL reset_hold cyc%0d got=%h want=%h", k, got, 16'h0000);
         end
      end
      reset = 1'b0;
      push_n(2, e(4'b0000, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b0000, 4'b0000, 4'b0000, 4'b1010));
      push_n(1, e(4'b1010, 4'b1010, 4'b0000, 4'b0000));
      push_n(2, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_release edge%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_rise();
      logic [15:0] got, want;
      bus.noisy = 4'b1011;
      push_n(2, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1010, 4'b0000, 4'b0000, 4'b0001));
      push_n(1, e(4'b1011, 4'b0001, 4'b0000, 4'b0000));
      push_n(1, e(4'b1011, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 9; k++) begin
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL rise_ch0 edge%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_glitch();
      logic [15:0] got, want;
      // Release channel 0 first, then a 4-cycle high glitch that must be rejected.
      bus.noisy = 4'b1010;
      push_n(2, e(4'b1011, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1011, 4'b0000, 4'b0000, 4'b0001));
      push_n(1, e(4'b1010, 4'b0000, 4'b0001, 4'b0000));
      push_n(1, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(2, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(4, e(4'b1010, 4'b0000, 4'b0000, 4'b0001));
      push_n(6, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 21; k++) begin
         if (k == 9)  bus.noisy = 4'b1011;
         if (k == 13) bus.noisy = 4'b1010;
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL glitch edge%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_bounce();
      logic [15:0] got, want;
      logic [3:0]  pat [5];
      pat = '{4'b1110, 4'b1010, 4'b1110, 4'b1010, 4'b1110};
      push_n(2, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(1, e(4'b1010, 4'b0000, 4'b0000, 4'b0100));
      push_n(1, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(1, e(4'b1010, 4'b0000, 4'b0000, 4'b0100));
      push_n(1, e(4'b1010, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1010, 4'b0000, 4'b0000, 4'b0100));
      push_n(1, e(4'b1110, 4'b0100, 4'b0000, 4'b0000));
      push_n(2, e(4'b1110, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 14; k++) begin
         if (k < 5) bus.noisy = pat[k];
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL bounce_ch2 edge%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] got, want;
      // Drop channel 1, then raise it and reset while it is qualifying.
      bus.noisy = 4'b1100;
      push_n(2, e(4'b1110, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1110, 4'b0000, 4'b0000, 4'b0010));
      push_n(1, e(4'b1100, 4'b0000, 4'b0010, 4'b0000));
      push_n(1, e(4'b1100, 4'b0000, 4'b0000, 4'b0000));
      push_n(2, e(4'b1100, 4'b0000, 4'b0000, 4'b0000));
      push_n(3, e(4'b1100, 4'b0000, 4'b0000, 4'b0010));
      push_n(4, e(4'b0000, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b0000, 4'b0000, 4'b0000, 4'b1110));
      push_n(1, e(4'b1110, 4'b1110, 4'b0000, 4'b0000));
      push_n(2, e(4'b1110, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 26; k++) begin
         if (k == 9)  bus.noisy = 4'b1110;
         if (k == 14) reset = 1'b1;
         if (k == 16) reset = 1'b0;
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_abort edge%0d got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got, want;
      bus.noisy = 4'b1111;
      push_n(2, e(4'b1110, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1110, 4'b0000, 4'b0000, 4'b0001));
      push_n(1, e(4'b1111, 4'b0001, 4'b0000, 4'b0000));
      push_n(1, e(4'b1111, 4'b0000, 4'b0000, 4'b0000));
      push_n(2, e(4'b1111, 4'b0000, 4'b0000, 4'b0000));
      push_n(5, e(4'b1111, 4'b0000, 4'b0000, 4'b1111));
      push_n(1, e(4'b0000, 4'b0000, 4'b1111, 4'b0000));
      push_n(2, e(4'b0000, 4'b0000, 4'b0000, 4'b0000));
      for (int k = 0; k < 19; k++) begin
         if (k == 9) bus.noisy = 4'b0000;
         @(posedge clock); #1;
         got  = {bus.clean, bus.rise, bus.fall, bus.busy};
         want = sbq.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL all_fall edge%0d got=%h want=%h", k, got, want);
         end
         total++;
         if ((bus.rise & bus.fall) !== 4'b0000) begin
            bad++;
            $display("FAIL rise_fall_overlap edge%0d got=%b want=0000", k, bus.rise & bus.fall);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.noisy = 4'b0000;
      test_reset();
      test_rise();
      test_glitch();
      test_bounce();
      test_reset_abort();
      test_back_to_back();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left got=%0d want=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
